// File: rtl/pc_seq.sv
// Program-counter sequencer: PC, registered Z flag, optional return-address
// stack compiled in with PC_SEQ_RET_STACK_EN.
module pc_seq #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              s_inc,
  input  logic              wez,
  input  logic              z_alu,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              z,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      z <= 1'b0;
    end else if (en && wez) begin
      z <= z_alu;
    end
  end

`ifdef PC_SEQ_RET_STACK_EN

  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PW:0]       sp;
  logic [PW-1:0]     top;
  logic              err;
  logic              is_jal;
  logic              is_ret;
  logic              push;
  logic              pop;
  logic              err_set;
  logic [ADDR_W-1:0] pc_next;

  assign is_jal    = opcode == 6'b101000;
  assign is_ret    = opcode == 6'b101001;
  assign top       = sp[PW-1:0] - PW'(1);
  assign stk_full  = sp == FULL_CNT;
  assign stk_empty = sp == '0;
  assign stk_err   = err;

  // JAL/RET outrank s_inc; stack boundary cases set the sticky error
  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (is_jal) begin
      pc_next = target;
      if (stk_full) err_set = 1'b1;
      else          push    = 1'b1;
    end else if (is_ret) begin
      if (stk_empty) begin
        err_set = 1'b1;
      end else begin
        pop     = 1'b1;
        pc_next = mem[top];
      end
    end else if (!s_inc) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      sp  <= '0;
      err <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (push)     sp <= sp + (PW+1)'(1);
      else if (pop) sp <= sp - (PW+1)'(1);
      if (err_set) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && en && push) begin
      mem[sp[PW-1:0]] <= pc_inc;
    end
  end

`else

  logic unused_cfg;

  assign unused_cfg = ^{opcode, STACK_DEPTH[0]};
  assign stk_full   = 1'b0;
  assign stk_empty  = 1'b1;
  assign stk_err    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (en) begin
      pc <= s_inc ? pc_inc : target;
    end
  end

`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: queue-based reference model checked every
// cycle, plus hand-computed literal checks of key points.
module tb_pc_seq;

  localparam int AW = 10;
  localparam int DEPTH = 8;
  localparam logic [5:0] OP_JAL = 6'b101000;
  localparam logic [5:0] OP_RET = 6'b101001;
  localparam logic [5:0] OP_NOP = 6'b000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          s_inc;
  logic          wez;
  logic          z_alu;
  logic [5:0]    opcode;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          z;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_err;

  int errors = 0;
  int checks = 0;

  pc_seq #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .s_inc(s_inc), .wez(wez),
    .z_alu(z_alu), .opcode(opcode), .target(target), .pc(pc), .z(z),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  // reference model
  int unsigned   m_pc = 0;
  bit            m_z = 0;
  bit            m_err = 0;
  int unsigned   m_stk[$];
  bit            started = 0;

`ifdef PC_SEQ_RET_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0;
      m_z = 0;
      m_err = 0;
      m_stk.delete();
      started = 1;
    end else if (en) begin
      int unsigned nxt;
      nxt = (m_pc + 1) % (1 << AW);
      if (wez) m_z = z_alu;
      if (STK && opcode == OP_JAL) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
        else m_err = 1;
        m_pc = target;
      end else if (STK && opcode == OP_RET) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_err = 1;
          m_pc = nxt;
        end
      end else if (s_inc) begin
        m_pc = nxt;
      end else begin
        m_pc = target;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("pc", int'(pc), int'(m_pc));
      chk("z", int'(z), int'(m_z));
      chk("stk_full", int'(stk_full), int'(STK && m_stk.size() == DEPTH));
      chk("stk_empty", int'(stk_empty), int'(m_stk.size() == 0));
      chk("stk_err", int'(stk_err), int'(m_err));
    end
  end

  // apply inputs at negedge, return just after the next rising edge
  task automatic step(input bit r, input bit e, input bit si, input bit w,
                      input bit za, input logic [5:0] op,
                      input logic [AW-1:0] tg);
    @(negedge clk);
    reset = r; en = e; s_inc = si; wez = w; z_alu = za;
    opcode = op; target = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [AW-1:0] tg);
    step(0, 1, 0, 0, 0, OP_NOP, tg);
  endtask

  initial begin
    reset = 1; en = 0; s_inc = 0; wez = 0; z_alu = 0;
    opcode = OP_NOP; target = '0;

    // reset has priority over en
    step(1, 1, 0, 1, 1, OP_NOP, 10'h3ff);
    chk("rst_pc", int'(pc), 0);
    chk("rst_z", int'(z), 0);
    chk("rst_empty", int'(stk_empty), 1);
    chk("rst_full", int'(stk_full), 0);
    chk("rst_err", int'(stk_err), 0);

    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 1, 0, 0, OP_NOP, 10'h2aa);
      chk("inc_pc", int'(pc), i);
    end

    go(10'h3ff);
    chk("jmp_3ff", int'(pc), 10'h3ff);
    step(0, 1, 1, 0, 0, OP_NOP, 10'h000);
    chk("wrap_pc", int'(pc), 0);
    go(10'h155);
    chk("jmp_155", int'(pc), 10'h155);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1, OP_NOP, 10'h000);
      chk("hold_pc", int'(pc), 10'h155);
      chk("hold_z", int'(z), 0);
    end

    step(0, 1, 1, 1, 1, OP_NOP, 10'h000);
    chk("z_set", int'(z), 1);
    step(0, 1, 1, 0, 0, OP_NOP, 10'h000);
    chk("z_keep", int'(z), 1);
    step(0, 1, 1, 1, 0, OP_NOP, 10'h000);
    chk("z_clr", int'(z), 0);

`ifdef PC_SEQ_RET_STACK_EN
    go(10'h010);
    step(0, 1, 1, 0, 0, OP_JAL, 10'h200);
    chk("jal_pc", int'(pc), 10'h200);
    chk("jal_nonempty", int'(stk_empty), 0);
    step(0, 1, 0, 0, 0, OP_RET, 10'h3ff);
    chk("ret_pc", int'(pc), 10'h011);
    chk("ret_empty", int'(stk_empty), 1);
    chk("ret_err", int'(stk_err), 0);

    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 1, 0, 0, OP_JAL, AW'(10'h100 + i * 16));
    end
    chk("full8", int'(stk_full), 1);
    step(0, 1, 1, 0, 0, OP_JAL, 10'h300);
    chk("ovf_pc", int'(pc), 10'h300);
    chk("ovf_err", int'(stk_err), 1);
    chk("ovf_full", int'(stk_full), 1);
    step(0, 1, 1, 0, 0, OP_RET, 10'h000);
    chk("ret1_pc", int'(pc), 10'h161);
    for (int i = 1; i < DEPTH - 1; i++) begin
      step(0, 1, 1, 0, 0, OP_RET, 10'h000);
    end
    chk("ret7_pc", int'(pc), 10'h101);
    step(0, 1, 1, 0, 0, OP_RET, 10'h000);
    chk("ret8_pc", int'(pc), 10'h012);
    go(10'h040);
    step(0, 1, 0, 0, 0, OP_RET, 10'h3ff);
    chk("unf_pc", int'(pc), 10'h041);
    chk("unf_err", int'(stk_err), 1);
    go(10'h080);
    chk("err_sticky", int'(stk_err), 1);

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, OP_JAL, AW'(10'h050 + i));
    end
    chk("three_nonempty", int'(stk_empty), 0);
`else
    go(10'h020);
    step(0, 1, 1, 0, 0, OP_JAL, 10'h200);
    chk("jal_ign_pc", int'(pc), 10'h021);
    step(0, 1, 0, 0, 0, OP_RET, 10'h1c0);
    chk("ret_ign_pc", int'(pc), 10'h1c0);
    chk("noflag_err", int'(stk_err), 0);
    chk("noflag_full", int'(stk_full), 0);
`endif

    step(0, 1, 1, 1, 1, OP_NOP, 10'h000);
    chk("pre_rst_z", int'(z), 1);
    step(1, 1, 0, 1, 1, OP_NOP, 10'h0f0);
    chk("mid_rst_pc", int'(pc), 0);
    chk("mid_rst_z", int'(z), 0);
    chk("mid_rst_empty", int'(stk_empty), 1);
    chk("mid_rst_err", int'(stk_err), 0);

`ifdef PC_SEQ_RET_STACK_EN
    // stack really discarded: RET now underflows
    step(0, 1, 0, 0, 0, OP_RET, 10'h0f0);
    chk("post_rst_ret_pc", int'(pc), 1);
    chk("post_rst_ret_err", int'(stk_err), 1);
`endif

    step(0, 1, 1, 0, 0, OP_NOP, 10'h000);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
